writeback_stage: RTL and testbench

- Final RV32I pipeline stage. Accepts one retiring instruction per cycle from the memory stage.
- Aligns and sign/zero-extends load data, then selects the writeback source: ALU, load, or PC+4.
- Drives the register-file write port and the WB forwarding bus.
- Keeps the 64-bit instret retirement counter for the CSR unit, and flags misaligned or illegal loads.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/load_align.sv | 64 ++++++
 rtl/writeback_stage.sv | 144 ++++++++++++++
 tb/tb_writeback_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I constants for the writeback stage and its load aligner:
//   XLEN            datapath width
//   WB_SEL_*        writeback source select codes (11 is reserved -> ALU)
//   F3_*            load funct3 width/sign codes
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-data aligner. Picks the addressed byte/half/word out of
// the raw memory word, sign- or zero-extends it, and flags misaligned or
// illegal (unknown funct3) loads.
// Ports:
//   i_word        raw 32-bit word read from data memory
//   i_off         byte offset within the word (effective address [1:0])
//   i_funct3      load width/sign code
//   o_data        aligned, extended load value
//   o_misaligned  halfword at odd offset, or word at nonzero offset
//   o_illegal     funct3 is not a defined load encoding
// -----------------------------------------------------------------------------
module load_align
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data,
    output logic            o_misaligned,
    output logic            o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Halfword selection ignores off[0]; an odd offset is reported as misaligned.
    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data       = '0;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_data = {24'b0, w_byte};
            F3_LH: begin
                o_data       = {{16{w_half[15]}}, w_half};
                o_misaligned = i_off[0];
            end
            F3_LHU: begin
                o_data       = {16'b0, w_half};
                o_misaligned = i_off[0];
            end
            F3_LW: begin
                o_data       = i_word;
                o_misaligned = (i_off != 2'd0);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final RV32I pipeline stage. Captures one retiring instruction per cycle from
// the memory stage, aligns load data, selects the writeback source and drives
// the register-file write port (which doubles as the WB forwarding bus).
// Also keeps the 64-bit instret counter and reports misaligned/illegal loads.
//
// Handshake: an instruction transfers on a clock edge when mem_valid is high
// and mem_ready (= !wb_stall) is high; flush additionally kills the transfer.
// A captured entry is live for exactly the following cycle and then retires.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_valid / mem_ready            memory-stage handshake
//   wb_stall, flush                  hazard hold, trap/redirect kill
//   mem_reg_write, mem_rd_addr       destination write flag and register
//   mem_wb_sel                       00 ALU, 01 load, 10 PC+4, 11 -> ALU
//   mem_is_load, mem_funct3          load qualifier and width/sign code
//   mem_alu_result                   ALU result / load effective address
//   mem_load_word, mem_pc_plus4      raw load word, link value
//   rf_write_enable/addr/data        register-file write port
//   load_exc, load_exc_addr          one-cycle load fault pulse, mtval
//   instret                          retired-instruction counter
//   csr_instret_we/hi/wdata          CSR half-word write into instret
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              wb_stall,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [1:0]        mem_wb_sel,
    input  logic              mem_is_load,
    input  logic [2:0]        mem_funct3,
    input  logic [XLEN-1:0]   mem_alu_result,
    input  logic [XLEN-1:0]   mem_load_word,
    input  logic [XLEN-1:0]   mem_pc_plus4,
    output logic              rf_write_enable,
    output logic [REG_AW-1:0] rf_write_addr,
    output logic [XLEN-1:0]   rf_write_data,
    output logic              load_exc,
    output logic [XLEN-1:0]   load_exc_addr,
    output logic [CNT_W-1:0]  instret,
    input  logic              csr_instret_we,
    input  logic              csr_instret_hi,
    input  logic [XLEN-1:0]   csr_instret_wdata
);

    import rv32_pkg::WB_SEL_LOAD;
    import rv32_pkg::WB_SEL_PC4;

    logic [XLEN-1:0]   w_load_data;
    logic              w_misaligned;
    logic              w_illegal;
    logic              w_capture;
    logic              w_exc;
    logic              w_retire;
    logic [XLEN-1:0]   w_wb_data;

    logic              r_wb_valid;
    logic              r_reg_write;
    logic              r_exc;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_data;
    logic [XLEN-1:0]   r_exc_addr;
    logic [CNT_W-1:0]  r_instret;

    load_align u_load_align (
        .i_word       (mem_load_word),
        .i_off        (mem_alu_result[1:0]),
        .i_funct3     (mem_funct3),
        .o_data       (w_load_data),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    assign mem_ready = ~wb_stall;
    assign w_capture = mem_valid & ~wb_stall & ~flush;
    // Alignment faults only matter for real loads; funct3 of other ops is not a load code.
    assign w_exc     = mem_is_load & (w_misaligned | w_illegal);

    always_comb begin
        case (mem_wb_sel)
            WB_SEL_LOAD: w_wb_data = w_load_data;
            WB_SEL_PC4:  w_wb_data = mem_pc_plus4;
            default:     w_wb_data = mem_alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid  <= 1'b0;
            r_reg_write <= 1'b0;
            r_exc       <= 1'b0;
            r_rd        <= '0;
            r_data      <= '0;
            r_exc_addr  <= '0;
        end else begin
            r_wb_valid <= w_capture;
            if (w_capture) begin
                r_reg_write <= mem_reg_write;
                r_exc       <= w_exc;
                r_rd        <= mem_rd_addr;
                r_data      <= w_wb_data;
                // mtval is sticky: only a new fault overwrites it.
                if (w_exc) begin
                    r_exc_addr <= mem_alu_result;
                end
            end
        end
    end

    assign w_retire = r_wb_valid & ~r_exc;

    // A CSR write in the same cycle as a retire wins and the increment is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (csr_instret_we) begin
            if (csr_instret_hi) begin
                r_instret[CNT_W-1:XLEN] <= csr_instret_wdata;
            end else begin
                r_instret[XLEN-1:0] <= csr_instret_wdata;
            end
        end else if (w_retire) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign rf_write_enable = r_wb_valid & r_reg_write & (r_rd != '0) & ~r_exc;
    assign rf_write_addr   = r_rd;
    assign rf_write_data   = r_data;
    assign load_exc        = r_wb_valid & r_exc;
    assign load_exc_addr   = r_exc_addr;
    assign instret         = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 64;

    logic              clk;
    logic              rst;
    logic              mem_valid;
    logic              mem_ready;
    logic              wb_stall;
    logic              flush;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd_addr;
    logic [1:0]        mem_wb_sel;
    logic              mem_is_load;
    logic [2:0]        mem_funct3;
    logic [XLEN-1:0]   mem_alu_result;
    logic [XLEN-1:0]   mem_load_word;
    logic [XLEN-1:0]   mem_pc_plus4;
    logic              rf_write_enable;
    logic [REG_AW-1:0] rf_write_addr;
    logic [XLEN-1:0]   rf_write_data;
    logic              load_exc;
    logic [XLEN-1:0]   load_exc_addr;
    logic [CNT_W-1:0]  instret;
    logic              csr_instret_we;
    logic              csr_instret_hi;
    logic [XLEN-1:0]   csr_instret_wdata;

    writeback_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .wb_stall          (wb_stall),
        .flush             (flush),
        .mem_reg_write     (mem_reg_write),
        .mem_rd_addr       (mem_rd_addr),
        .mem_wb_sel        (mem_wb_sel),
        .mem_is_load       (mem_is_load),
        .mem_funct3        (mem_funct3),
        .mem_alu_result    (mem_alu_result),
        .mem_load_word     (mem_load_word),
        .mem_pc_plus4      (mem_pc_plus4),
        .rf_write_enable   (rf_write_enable),
        .rf_write_addr     (rf_write_addr),
        .rf_write_data     (rf_write_data),
        .load_exc          (load_exc),
        .load_exc_addr     (load_exc_addr),
        .instret           (instret),
        .csr_instret_we    (csr_instret_we),
        .csr_instret_hi    (csr_instret_hi),
        .csr_instret_wdata (csr_instret_wdata)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_instret;
    logic        pending_inc;
    logic [31:0] exp_exc_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Byte/half picked by shifting and modulo, sign applied by adding the
    // upper ones pattern when the value is in the negative half of its range.
    function automatic void ref_load(input logic [31:0] word, input logic [31:0] addr,
                                     input logic [2:0] f3,
                                     output logic [31:0] data, output logic exc);
        int unsigned off, b, h;
        off  = addr % 4;
        b    = (word >> (8 * off)) % 256;
        h    = (word >> (16 * (off / 2))) % 65536;
        data = 32'd0;
        exc  = 1'b0;
        case (f3)
            3'd0: data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4: data = b;
            3'd1: begin data = (h >= 32768) ? h + 32'hFFFF_0000 : h; exc = (off % 2) != 0; end
            3'd5: begin data = h; exc = (off % 2) != 0; end
            3'd2: begin data = word; exc = (off != 0); end
            default: exc = 1'b1;
        endcase
    endfunction

    function automatic void ref_wb(input logic valid, input logic stall, input logic fl,
                                   input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                                   input logic is_ld, input logic [2:0] f3,
                                   input logic [31:0] alu, input logic [31:0] word,
                                   input logic [31:0] pc4,
                                   output logic cap, output logic we,
                                   output logic [31:0] data, output logic exc);
        logic [31:0] ld;
        logic        lexc;
        ref_load(word, alu, f3, ld, lexc);
        cap  = valid && !stall && !fl;
        exc  = cap && is_ld && lexc;
        data = (sel == 2'd1) ? ld : (sel == 2'd2) ? pc4 : alu;
        we   = cap && rw && (rd != 5'd0) && !exc;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        valid, stall, fl, rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic        is_ld;
        logic [2:0]  f3;
        logic [31:0] alu, word, pc4;
        logic        e_we;
        logic [31:0] e_data;
        logic        e_exc;
        logic        e_inc;
    } vec_t;

    function automatic vec_t mk(input logic valid, input logic stall, input logic fl,
                                input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                                input logic is_ld, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] word,
                                input logic [31:0] pc4, input logic e_we,
                                input logic [31:0] e_data, input logic e_exc, input logic e_inc);
        vec_t v;
        v.valid = valid; v.stall = stall; v.fl = fl; v.rw = rw; v.rd = rd; v.sel = sel;
        v.is_ld = is_ld; v.f3 = f3; v.alu = alu; v.word = word; v.pc4 = pc4;
        v.e_we = e_we; v.e_data = e_data; v.e_exc = e_exc; v.e_inc = e_inc;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        mem_valid = 0; wb_stall = 0; flush = 0; mem_reg_write = 0; mem_rd_addr = '0;
        mem_wb_sel = '0; mem_is_load = 0; mem_funct3 = '0; mem_alu_result = '0;
        mem_load_word = '0; mem_pc_plus4 = '0; csr_instret_we = 0; csr_instret_hi = 0;
        csr_instret_wdata = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        mem_valid = v.valid; wb_stall = v.stall; flush = v.fl; mem_reg_write = v.rw;
        mem_rd_addr = v.rd; mem_wb_sel = v.sel; mem_is_load = v.is_ld; mem_funct3 = v.f3;
        mem_alu_result = v.alu; mem_load_word = v.word; mem_pc_plus4 = v.pc4;
        csr_instret_we = 0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] alu);
        drive_idle();
        mem_valid = 1; mem_reg_write = 1; mem_rd_addr = rd; mem_alu_result = alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic hi, input logic [31:0] val);
        drive_idle();
        csr_instret_we = 1; csr_instret_hi = hi; csr_instret_wdata = val;
        tick();
        csr_instret_we = 0;
    endtask

    vec_t tbl[22];

    initial begin
        int writes;
        logic c_cap, c_we, c_exc;
        logic [31:0] c_data;

        tbl[0]  = mk(1,0,0,1,5,1,1,3'd0,32'h2001,32'h80FF7F01,0, 1,32'h0000007F,0,1);
        tbl[1]  = mk(1,0,0,1,5,1,1,3'd0,32'h2003,32'h80FF7F01,0, 1,32'hFFFFFF80,0,1);
        tbl[2]  = mk(1,0,0,1,5,1,1,3'd4,32'h2003,32'h80FF7F01,0, 1,32'h00000080,0,1);
        tbl[3]  = mk(1,0,0,1,6,1,1,3'd1,32'h1002,32'h80011234,0, 1,32'hFFFF8001,0,1);
        tbl[4]  = mk(1,0,0,1,6,1,1,3'd1,32'h1001,32'h80011234,0, 0,32'h0,1,0);
        tbl[5]  = mk(1,0,0,1,6,1,1,3'd3,32'h1000,32'h80011234,0, 0,32'h0,1,0);
        tbl[6]  = mk(1,0,0,1,0,0,0,3'd0,32'hDEADBEEF,0,0,        0,32'h0,0,1);
        tbl[7]  = mk(1,0,0,1,1,2,0,3'd0,32'h55,0,32'h104,        1,32'h00000104,0,1);
        tbl[8]  = mk(1,0,0,1,8,1,1,3'd5,32'h2003,32'h11223344,0, 0,32'h0,1,0);
        tbl[9]  = mk(1,0,0,1,9,1,1,3'd2,32'h2000,32'hCAFEF00D,0, 1,32'hCAFEF00D,0,1);
        tbl[10] = mk(1,0,0,1,9,1,1,3'd2,32'h2002,32'hCAFEF00D,0, 0,32'h0,1,0);
        tbl[11] = mk(1,0,0,1,7,3,0,3'd0,32'h12345678,0,32'h99,   1,32'h12345678,0,1);
        tbl[12] = mk(1,0,1,1,7,1,1,3'd2,32'h3001,32'h1,0,        0,32'h0,0,0);
        tbl[13] = mk(1,1,0,1,7,1,1,3'd2,32'h3001,32'h1,0,        0,32'h0,0,0);
        tbl[14] = mk(0,0,0,1,7,0,0,3'd0,32'h77,0,0,              0,32'h0,0,0);
        tbl[15] = mk(1,0,0,1,10,1,1,3'd5,32'h1002,32'h80011234,0,1,32'h00008001,0,1);
        tbl[16] = mk(1,0,0,1,11,1,1,3'd6,32'h4000,32'h5,0,       0,32'h0,1,0);
        tbl[17] = mk(1,0,0,1,11,1,1,3'd7,32'h4004,32'h5,0,       0,32'h0,1,0);
        tbl[18] = mk(1,0,0,0,4,0,0,3'd0,32'hABCD,0,0,            0,32'h0,0,1);
        tbl[19] = mk(1,0,0,1,12,0,0,3'd3,32'h4001,0,0,           1,32'h00004001,0,1);
        tbl[20] = mk(1,0,0,1,31,1,1,3'd0,32'h5000,32'h000000F0,0,1,32'hFFFFFFF0,0,1);
        tbl[21] = mk(1,0,0,1,13,1,1,3'd1,32'h5000,32'h00007FFF,0,1,32'h00007FFF,0,1);

        // ---------------- reset ----------------
        drive_idle();
        rst = 1;
        tick();
        tick();
        check("rst_we", rf_write_enable, 0);
        check("rst_addr", rf_write_addr, 0);
        check("rst_data", rf_write_data, 0);
        check("rst_exc", load_exc, 0);
        check("rst_exc_addr", load_exc_addr, 0);
        check("rst_instret", instret, 0);
        rst = 0;
        exp_instret  = 0;
        pending_inc  = 0;
        exp_exc_addr = 0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 22; i++) begin
            drive_vec(tbl[i]);
            #1;
            check($sformatf("tbl%0d_ready", i), mem_ready, !tbl[i].stall);
            tick();
            exp_instret = exp_instret + pending_inc;
            pending_inc = tbl[i].e_inc;
            if (tbl[i].e_exc) exp_exc_addr = tbl[i].alu;
            check($sformatf("tbl%0d_we", i), rf_write_enable, tbl[i].e_we);
            if (tbl[i].e_we) begin
                check($sformatf("tbl%0d_addr", i), rf_write_addr, tbl[i].rd);
                check($sformatf("tbl%0d_data", i), rf_write_data, tbl[i].e_data);
            end
            check($sformatf("tbl%0d_exc", i), load_exc, tbl[i].e_exc);
            check($sformatf("tbl%0d_exc_addr", i), load_exc_addr, exp_exc_addr);
            check($sformatf("tbl%0d_instret", i), instret, exp_instret);
        end
        drive_idle();
        tick();
        exp_instret = exp_instret + pending_inc;
        check("tbl_final_instret", instret, exp_instret);

        // ---------------- back-to-back with one stall ----------------
        rst = 1;
        tick();
        rst = 0;
        writes = 0;
        for (int c = 0; c < 4; c++) begin
            drive_alu(5'(c + 2), 32'h100 + c);
            wb_stall = (c == 1);
            #1;
            check($sformatf("b2b%0d_ready", c), mem_ready, (c != 1));
            tick();
            if (rf_write_enable) writes++;
            check($sformatf("b2b%0d_we", c), rf_write_enable, (c != 1));
        end
        drive_idle();
        tick();
        check("b2b_idle_we", rf_write_enable, 0);
        check("b2b_writes", writes, 3);
        check("b2b_instret", instret, 3);

        // valid with flush: nothing written, nothing retired
        drive_alu(5'd3, 32'h42);
        flush = 1;
        tick();
        check("flush_we", rf_write_enable, 0);
        drive_idle();
        tick();
        check("flush_instret", instret, 3);

        // ---------------- instret CSR writes and carry ----------------
        csr_write(0, 32'hFFFF_FFFF);
        csr_write(1, 32'h0);
        check("csr_preset", instret, 64'h0000_0000_FFFF_FFFF);
        drive_alu(5'd3, 32'h1);
        tick();
        drive_idle();
        tick();
        check("csr_carry", instret, 64'h0000_0001_0000_0000);
        drive_alu(5'd3, 32'h2);
        tick();
        csr_write(0, 32'd5);
        check("csr_wins", instret, 64'h0000_0001_0000_0005);
        tick();
        check("csr_no_late_inc", instret, 64'h0000_0001_0000_0005);

        csr_write(1, 32'hFFFF_FFFF);
        csr_write(0, 32'hFFFF_FFFF);
        drive_alu(5'd3, 32'h3);
        tick();
        drive_idle();
        tick();
        check("instret_wrap", instret, 64'h0);

        // ---------------- reset while an entry is live ----------------
        drive_alu(5'd9, 32'hA5A5_0001);
        tick();
        drive_alu(5'd9, 32'hA5A5_0002);
        tick();
        check("live_we", rf_write_enable, 1);
        check("live_instret", instret, 1);
        drive_idle();
        rst = 1;
        tick();
        check("midrst_we", rf_write_enable, 0);
        check("midrst_instret", instret, 0);
        check("midrst_exc", load_exc, 0);
        check("midrst_data", rf_write_data, 0);
        rst = 0;

        // ---------------- randomized traffic vs model ----------------
        exp_instret  = 0;
        pending_inc  = 0;
        exp_exc_addr = 0;
        for (int n = 0; n < 400; n++) begin
            mem_valid         = ($urandom_range(0, 3) != 0);
            wb_stall          = ($urandom_range(0, 5) == 0);
            flush             = ($urandom_range(0, 7) == 0);
            mem_reg_write     = $urandom_range(0, 1);
            mem_rd_addr       = 5'($urandom_range(0, 31));
            mem_wb_sel        = 2'($urandom_range(0, 3));
            mem_is_load       = $urandom_range(0, 1);
            mem_funct3        = 3'($urandom_range(0, 7));
            mem_alu_result    = $urandom;
            mem_load_word     = $urandom;
            mem_pc_plus4      = $urandom;
            csr_instret_we    = ($urandom_range(0, 19) == 0);
            csr_instret_hi    = $urandom_range(0, 1);
            csr_instret_wdata = $urandom_range(0, 255);
            ref_wb(mem_valid, wb_stall, flush, mem_reg_write, mem_rd_addr, mem_wb_sel,
                   mem_is_load, mem_funct3, mem_alu_result, mem_load_word, mem_pc_plus4,
                   c_cap, c_we, c_data, c_exc);
            #1;
            check($sformatf("rnd%0d_ready", n), mem_ready, !wb_stall);
            if (csr_instret_we) begin
                if (csr_instret_hi) exp_instret[63:32] = csr_instret_wdata;
                else                exp_instret[31:0]  = csr_instret_wdata;
            end else begin
                exp_instret = exp_instret + pending_inc;
            end
            pending_inc = c_cap && !c_exc;
            if (c_exc) exp_exc_addr = mem_alu_result;
            tick();
            check($sformatf("rnd%0d_we", n), rf_write_enable, c_we);
            if (c_we) begin
                check($sformatf("rnd%0d_addr", n), rf_write_addr, mem_rd_addr);
                check($sformatf("rnd%0d_data", n), rf_write_data, c_data);
            end
            check($sformatf("rnd%0d_exc", n), load_exc, c_exc);
            check($sformatf("rnd%0d_exc_addr", n), load_exc_addr, exp_exc_addr);
            check($sformatf("rnd%0d_instret", n), instret, exp_instret);
        end

        // ---------------- report ----------------
        drive_idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
